kcpsmx_scratch_ctrl: RTL and testbench

Pipeline stage between the execute stage and the 64x8 scratchpad RAM. It executes STORE/FETCH requests, posts stores through a one-entry store buffer, forwards buffered data to fetches to the same address, and registers fetch results for writeback. After reset it clears the scratchpad to zero, because the RAM contents are undefined after reset.

---
 rtl/kcpsmx_scratch_ctrl.sv | 117 +++++++++++
 tb/tb_kcpsmx_scratch_ctrl.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/kcpsmx_scratch_ctrl.sv
// Scratchpad access stage: posts STOREs through a one-entry buffer, forwards to
// FETCHes, registers fetch results for writeback, and zero-fills the RAM after reset.
//
// state | meaning
// INIT  | zero-fill sweep over every scratchpad location, requests stalled
// RUN   | normal STORE/FETCH service
module kcpsmx_scratch_ctrl #(
    parameter int SCRATCH_DEPTH  = 6,
    parameter int SCRATCH_WIDTH  = 8,
    parameter int SCRATCH_SIZE   = 64,
    parameter int REG_IDX_W      = 4,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic                     req_store,
    input  logic                     req_fetch,
    input  logic [SCRATCH_DEPTH-1:0] req_addr,
    input  logic [SCRATCH_WIDTH-1:0] req_wdata,
    input  logic [REG_IDX_W-1:0]     req_dest,
    output logic                     req_ready,
    input  logic                     flush,
    input  logic                     wb_hold,
    output logic                     wb_valid,
    output logic [REG_IDX_W-1:0]     wb_dest,
    output logic [SCRATCH_WIDTH-1:0] wb_data,
    output logic [SCRATCH_DEPTH-1:0] sp_addr,
    output logic                     sp_we,
    output logic [SCRATCH_WIDTH-1:0] sp_wdata,
    input  logic [SCRATCH_WIDTH-1:0] sp_rdata,
    output logic                     busy,
    output logic                     protocol_err
);

    typedef enum logic {INIT, RUN} state_t;

    localparam logic [SCRATCH_DEPTH-1:0] CLR_LAST = SCRATCH_DEPTH'(SCRATCH_SIZE - 1);

    state_t                   state;
    logic [SCRATCH_DEPTH-1:0] clr_cnt;
    logic                     sb_valid;
    logic [SCRATCH_DEPTH-1:0] sb_addr;
    logic [SCRATCH_WIDTH-1:0] sb_data;

    logic addr_conflict;
    logic accept;
    logic acc_store;
    logic acc_fetch;
    logic fwd_hit;

    // A fetch to a different address than the buffered store would need the
    // single RAM port in the same cycle as the drain, so it waits one cycle.
    assign addr_conflict = req_fetch && sb_valid && (sb_addr != req_addr);
    assign req_ready     = (state == RUN) && !flush && !(wb_valid && wb_hold) && !addr_conflict;
    assign accept        = req_valid && req_ready;
    assign acc_store     = accept && req_store;
    assign acc_fetch     = accept && req_fetch && !req_store;
    assign fwd_hit       = sb_valid && (sb_addr == req_addr);
    assign busy          = (state == INIT) && !reset;

    always_comb begin
        sp_addr  = '0;
        sp_we    = 1'b0;
        sp_wdata = '0;
        if (state == INIT) begin
            sp_addr  = clr_cnt;
            sp_we    = !reset;
        end else begin
            sp_addr  = sb_valid ? sb_addr : req_addr;
            sp_we    = sb_valid && !reset;
            sp_wdata = sb_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= (CLEAR_ON_RESET != 0) ? INIT : RUN;
            clr_cnt      <= '0;
            sb_valid     <= 1'b0;
            sb_addr      <= '0;
            sb_data      <= '0;
            wb_valid     <= 1'b0;
            wb_dest      <= '0;
            wb_data      <= '0;
            protocol_err <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    clr_cnt <= clr_cnt + 1'b1;
                    if (clr_cnt == CLR_LAST)
                        state <= RUN;
                end
                RUN: begin
                    sb_valid <= acc_store;
                    if (acc_store) begin
                        sb_addr <= req_addr;
                        sb_data <= req_wdata;
                        if (req_fetch)
                            protocol_err <= 1'b1;
                    end
                    if (flush) begin
                        wb_valid <= 1'b0;
                    end else if (acc_fetch) begin
                        wb_valid <= 1'b1;
                        wb_dest  <= req_dest;
                        wb_data  <= fwd_hit ? sb_data : sp_rdata;
                    end else if (!(wb_valid && wb_hold)) begin
                        wb_valid <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_kcpsmx_scratch_ctrl.sv
// Bench for kcpsmx_scratch_ctrl: behavioural 64x8 RAM, directed vector table,
// and randomized traffic checked against an architectural memory model.
module tb_kcpsmx_scratch_ctrl;

    logic       clk;
    logic       reset;
    logic       req_valid, req_store, req_fetch;
    logic [5:0] req_addr;
    logic [7:0] req_wdata;
    logic [3:0] req_dest;
    logic       req_ready;
    logic       flush, wb_hold;
    logic       wb_valid;
    logic [3:0] wb_dest;
    logic [7:0] wb_data;
    logic [5:0] sp_addr;
    logic       sp_we;
    logic [7:0] sp_wdata;
    logic [7:0] sp_rdata;
    logic       busy;
    logic       protocol_err;

    int errors = 0;
    int checks = 0;

    logic [7:0] ram [64];

    kcpsmx_scratch_ctrl dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_store(req_store), .req_fetch(req_fetch),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_dest(req_dest),
        .req_ready(req_ready), .flush(flush), .wb_hold(wb_hold),
        .wb_valid(wb_valid), .wb_dest(wb_dest), .wb_data(wb_data),
        .sp_addr(sp_addr), .sp_we(sp_we), .sp_wdata(sp_wdata), .sp_rdata(sp_rdata),
        .busy(busy), .protocol_err(protocol_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign sp_rdata = ram[sp_addr];
    always @(posedge clk)
        if (sp_we) ram[sp_addr] <= sp_wdata;

    task automatic check(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 0; req_store = 0; req_fetch = 0;
        req_addr = 0; req_wdata = 0; req_dest = 0;
        flush = 0; wb_hold = 0;
    endtask

    // abort > 0 re-enters reset-free operation after that many clear cycles
    task automatic reset_and_clear(input int abort);
        int n;
        int bad;
        bit done;
        n = 0; bad = 0; done = 0;
        idle_inputs();
        req_valid = 1; req_store = 1; req_addr = 6'h10; req_wdata = 8'h77;
        reset = 1;
        @(negedge clk);
        check("reset_sp_we", sp_we, 0);
        check("reset_busy", busy, 0);
        @(posedge clk); #1;
        check("reset_wb_valid", wb_valid, 0);
        check("reset_perr", protocol_err, 0);
        reset = 0;
        idle_inputs();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!busy) done = 1;
            else begin
                if (sp_we !== 1'b1 || sp_addr !== n[5:0] || sp_wdata !== 8'h00 || req_ready !== 1'b0)
                    bad++;
                n++;
            end
            @(posedge clk); #1;
            if (done || (abort > 0 && n == abort)) break;
        end
        if (abort == 0) begin
            int nz;
            nz = 0;
            check("clear_len", n, 64);
            check("clear_seq", bad, 0);
            for (int a = 0; a < 64; a++) if (ram[a] !== 8'h00) nz++;
            check("clear_ram_zero", nz, 0);
        end
    endtask

    typedef struct packed {
        logic       v, st, fe;
        logic [5:0] a;
        logic [7:0] d;
        logic [3:0] dest;
        logic       fl, hd;
        logic       e_rdy, e_we, e_wbv;
        logic [7:0] e_wbd;
        logic [3:0] e_dst;
        logic       e_perr;
    } vec_t;

    function automatic vec_t mk(logic v, logic st, logic fe, logic [5:0] a, logic [7:0] d,
                                logic [3:0] dest, logic fl, logic hd, logic e_rdy, logic e_we,
                                logic e_wbv, logic [7:0] e_wbd, logic [3:0] e_dst, logic e_perr);
        vec_t r;
        r = {v, st, fe, a, d, dest, fl, hd, e_rdy, e_we, e_wbv, e_wbd, e_dst, e_perr};
        return r;
    endfunction

    localparam int NV = 22;
    vec_t tbl [NV];

    logic [7:0] am [64];
    logic       m_wbv, m_perr, m_pend;
    logic [3:0] m_dest;
    logic [7:0] m_data;
    logic [5:0] m_paddr;

    initial begin
        logic [5:0] chk_a [6];
        logic [7:0] chk_d [6];
        logic       e_rdy, acc, last_acc;
        int         r;

        for (int i = 0; i < 64; i++) ram[i] = 8'($urandom);
        idle_inputs();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;

        reset_and_clear(0);
        check("post_clear_wb_valid", wb_valid, 0);

        //        v st fe addr   data   dst fl hd | rdy we wbv wbd   dst perr
        tbl[0]  = mk(1, 0, 1, 6'h2A, 8'h00, 1, 0, 0, 1, 0, 1, 8'h00, 1, 0);
        tbl[1]  = mk(1, 1, 0, 6'h15, 8'hA5, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        tbl[2]  = mk(1, 0, 1, 6'h15, 8'h00, 2, 0, 0, 1, 1, 1, 8'hA5, 2, 0);
        tbl[3]  = mk(1, 1, 0, 6'h02, 8'h22, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        tbl[4]  = mk(1, 1, 0, 6'h01, 8'h11, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0);
        tbl[5]  = mk(1, 0, 1, 6'h02, 8'h00, 3, 0, 0, 0, 1, 0, 8'h00, 0, 0);
        tbl[6]  = mk(1, 0, 1, 6'h02, 8'h00, 3, 0, 0, 1, 0, 1, 8'h22, 3, 0);
        tbl[7]  = mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        tbl[8]  = mk(1, 1, 0, 6'h03, 8'h33, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        tbl[9]  = mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 0, 0);
        tbl[10] = mk(1, 0, 1, 6'h03, 8'h00, 4, 0, 0, 1, 0, 1, 8'h33, 4, 0);
        tbl[11] = mk(1, 0, 1, 6'h04, 8'h00, 5, 0, 1, 0, 0, 1, 8'h33, 4, 0);
        tbl[12] = mk(1, 0, 1, 6'h04, 8'h00, 5, 0, 1, 0, 0, 1, 8'h33, 4, 0);
        tbl[13] = mk(1, 0, 1, 6'h04, 8'h00, 5, 0, 1, 0, 0, 1, 8'h33, 4, 0);
        tbl[14] = mk(1, 0, 1, 6'h04, 8'h00, 5, 0, 0, 1, 0, 1, 8'h00, 5, 0);
        tbl[15] = mk(1, 1, 0, 6'h3F, 8'hFF, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        tbl[16] = mk(1, 0, 1, 6'h3F, 8'h00, 6, 0, 0, 1, 1, 1, 8'hFF, 6, 0);
        tbl[17] = mk(1, 0, 1, 6'h07, 8'h00, 7, 1, 1, 0, 0, 0, 8'h00, 0, 0);
        tbl[18] = mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 0);
        tbl[19] = mk(1, 1, 1, 6'h07, 8'h5C, 0, 0, 0, 1, 0, 0, 8'h00, 0, 1);
        tbl[20] = mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 1, 0, 8'h00, 0, 1);
        tbl[21] = mk(0, 0, 0, 6'h00, 8'h00, 0, 0, 0, 1, 0, 0, 8'h00, 0, 1);

        for (int i = 0; i < NV; i++) begin
            req_valid = tbl[i].v;  req_store = tbl[i].st; req_fetch = tbl[i].fe;
            req_addr  = tbl[i].a;  req_wdata = tbl[i].d;  req_dest  = tbl[i].dest;
            flush     = tbl[i].fl; wb_hold   = tbl[i].hd;
            @(negedge clk);
            check($sformatf("v%0d_ready", i), req_ready, tbl[i].e_rdy);
            check($sformatf("v%0d_sp_we", i), sp_we, tbl[i].e_we);
            @(posedge clk); #1;
            check($sformatf("v%0d_wb_valid", i), wb_valid, tbl[i].e_wbv);
            if (tbl[i].e_wbv) begin
                check($sformatf("v%0d_wb_data", i), wb_data, tbl[i].e_wbd);
                check($sformatf("v%0d_wb_dest", i), wb_dest, tbl[i].e_dst);
            end
            check($sformatf("v%0d_perr", i), protocol_err, tbl[i].e_perr);
        end

        chk_a = '{6'h15, 6'h02, 6'h01, 6'h03, 6'h3F, 6'h07};
        chk_d = '{8'hA5, 8'h22, 8'h11, 8'h33, 8'hFF, 8'h5C};
        for (int i = 0; i < 6; i++)
            check($sformatf("dir_ram_%0h", chk_a[i]), ram[chk_a[i]], chk_d[i]);

        // reset during the clear sweep must restart it from address 0
        reset_and_clear(10);
        reset_and_clear(0);
        check("perr_cleared", protocol_err, 0);

        for (int i = 0; i < 64; i++) am[i] = 8'h00;
        m_wbv = 0; m_perr = 0; m_pend = 0; m_dest = 0; m_data = 0; m_paddr = 0;
        last_acc = 1;
        req_valid = 0;
        for (int c = 0; c < 600; c++) begin
            if (!(req_valid && !last_acc)) begin
                req_valid = ($urandom_range(0, 9) < 7);
                r = $urandom_range(0, 19);
                req_store = (r < 8) || (r == 19);
                req_fetch = (r >= 8 && r < 17) || (r == 19);
                req_addr  = ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63))
                                                          : 6'($urandom_range(0, 7));
                req_wdata = 8'($urandom);
                req_dest  = 4'($urandom);
            end
            flush   = ($urandom_range(0, 9) == 0);
            wb_hold = ($urandom_range(0, 9) < 3);
            @(negedge clk);
            e_rdy = !flush && !(m_wbv && wb_hold) && !(req_fetch && m_pend && m_paddr != req_addr);
            check("rand_ready", req_ready, e_rdy);
            acc = req_valid && e_rdy;
            @(posedge clk); #1;
            if (flush) m_wbv = 0;
            else if (acc && req_fetch && !req_store) begin
                m_wbv = 1; m_dest = req_dest; m_data = am[req_addr];
            end else if (!(m_wbv && wb_hold)) m_wbv = 0;
            if (acc && req_store) begin
                am[req_addr] = req_wdata;
                if (req_fetch) m_perr = 1;
            end
            m_pend  = acc && req_store;
            m_paddr = req_addr;
            check("rand_wb_valid", wb_valid, m_wbv);
            if (m_wbv) begin
                check("rand_wb_data", wb_data, m_data);
                check("rand_wb_dest", wb_dest, m_dest);
            end
            check("rand_perr", protocol_err, m_perr);
            last_acc = acc;
        end

        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 64; i++)
            check($sformatf("rand_ram_%0h", i), ram[i], am[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
